instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter INS_ADDRESS, default 9, byte-address width of instruction memory.
REQ-002 SHALL have parameter INS_W, default 32, instruction width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-006 SHALL have port ra  output  INS_ADDRESS  byte read address to the instruction memory; always equal to the current pc.
REQ-007 SHALL have port rd  input  INS_W  read data from the instruction memory; combinational, valid in the same cycle as ra.
REQ-008 SHALL have port redirect  input  1  branch/jump taken; overrides all other events.
REQ-009 SHALL have port redirect_pc  input  INS_ADDRESS  new fetch byte address.
REQ-010 SHALL have port out_ready  input  1  decode stage accepts the head instruction.
REQ-011 SHALL have port out_valid  output  1  head instruction is valid.
REQ-012 SHALL have port out_instr  output  INS_W  head instruction word.
REQ-013 SHALL have port out_pc  output  INS_ADDRESS  byte address of the head instruction.

Function
REQ-014 SHALL implement states IDLE, RUN and FLUSH.
REQ-015 IDLE: no fetch, buffer empty; start=1 SHALL move to RUN on the next edge.
REQ-016 RUN: fetch each cycle when can_push; redirect=1 SHALL move to FLUSH.
REQ-017 FLUSH: lasts exactly one cycle, no fetch, then returns to RUN; redirect=1 in FLUSH SHALL reload pc and stay in FLUSH.
REQ-018 SHALL hold a 2-entry FIFO of {pc, instr}; the head drives out_pc/out_instr; out_valid = (count != 0).
REQ-019 Pop SHALL occur when out_valid && out_ready.
REQ-020 can_push SHALL be (count < 2) || pop, i.e. simultaneous pop and push when full is allowed, leaving count unchanged.
REQ-021 Fetch in RUN with can_push and no redirect SHALL push {pc, rd} and set pc <= pc + 4.
REQ-022 pc arithmetic SHALL be INS_ADDRESS bits, modulo 2^INS_ADDRESS: 0x1FC + 4 -> 0x000.
REQ-023 pc[1:0] SHALL always be 0; redirect_pc[1:0] SHALL be ignored (forced to 0).
REQ-024 redirect=1 (RUN or FLUSH) SHALL set pc <= {redirect_pc[INS_ADDRESS-1:2], 2'b00}, clear the FIFO (count <= 0) and discard any pop/push that cycle.
REQ-025 Fetch-to-out_valid latency SHALL be 1 cycle; redirect-to-first-valid latency SHALL be 2 cycles (FLUSH bubble + fetch).
REQ-026 When out_valid=1 and out_ready=0, out_instr/out_pc SHALL remain stable until popped or flushed.
REQ-027 start SHALL be ignored outside IDLE; redirect SHALL be ignored in IDLE.

Reset
REQ-028 reset=1 on an edge SHALL set state=IDLE, pc=0, count=0, out_valid=0, out_instr=0, out_pc=0, overriding every other input.
REQ-029 Reset asserted mid-operation SHALL discard buffered instructions; ra SHALL read 0 in the following cycle.

Verification
REQ-030 Memory word0=0x00007033, word1=0x00100093, word2=0x00200113; reset, start, out_ready=1 -> out_valid rises 1 cycle after RUN entry; out_pc/out_instr = 0x000/0x00007033, 0x004/0x00100093, 0x008/0x00200113 on consecutive cycles.
REQ-031 out_ready=0 for 5 cycles in RUN -> count saturates at 2, pc stops 8 bytes past head, head stays 0x000/0x00007033; releasing out_ready -> 0x004 then 0x008 delivered with no loss or duplication.
REQ-032 redirect=1, redirect_pc=0x02B with 2 entries buffered -> out_valid=0 next cycle (FLUSH); next valid out_pc=0x028 two cycles after redirect.
REQ-033 pc at 0x1FC with out_ready=1 -> out_pc 0x1FC followed by 0x000.
REQ-034 reset asserted while count=2 and in RUN -> next cycle out_valid=0, ra=0, state IDLE; no fetch until start.
REQ-035 redirect and pop asserted together while full -> FIFO empty after edge, popped entry not re-presented, pc = new target.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch: pc sequencing, redirect flush and a 2-entry {pc, instr}
// skid buffer feeding decode. Memory read is combinational on ra.
module instruction_fetch #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [INS_ADDRESS-1:0] ra,
  input  logic [INS_W-1:0]       rd,
  input  logic                   redirect,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [INS_W-1:0]       out_instr,
  output logic [INS_ADDRESS-1:0] out_pc
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  typedef struct packed {
    logic [INS_ADDRESS-1:0] pc;
    logic [INS_W-1:0]       instr;
  } entry_t;

  state_e                 state_q, state_d;
  logic [INS_ADDRESS-1:0] pc_q, pc_d;
  logic [1:0]             count_q, count_d;
  entry_t [1:0]           fifo_q, fifo_d;

  logic   fetch_en, redirect_en;
  logic   pop, push, can_push;
  entry_t new_e;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      count_q <= '0;
      fifo_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      fifo_q  <= fifo_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (redirect) state_d = FLUSH;
      FLUSH:   state_d = redirect ? FLUSH : RUN;
      default: state_d = IDLE;
    endcase
  end

  // state-decoded controls; IDLE ignores redirect entirely
  always_comb begin
    fetch_en    = (state_q == RUN);
    redirect_en = (state_q != IDLE) && redirect;
  end

  assign out_valid = (count_q != 2'd0);
  assign out_pc    = fifo_q[0].pc;
  assign out_instr = fifo_q[0].instr;
  assign ra        = pc_q;

  assign pop      = out_valid && out_ready;
  assign can_push = (count_q < 2'd2) || pop;
  assign push     = fetch_en && can_push && !redirect_en;

  always_comb begin
    new_e.pc    = pc_q;
    new_e.instr = rd;
  end

  // fifo_q[0] is always the head; entries shift down on pop
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    fifo_d  = fifo_q;
    if (redirect_en) begin
      pc_d    = redirect_pc & ~INS_ADDRESS'(3);
      count_d = '0;
    end else begin
      if (push) pc_d = pc_q + INS_ADDRESS'(4);
      case ({push, pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            fifo_d[0] = fifo_q[1];
            fifo_d[1] = new_e;
          end else begin
            fifo_d[0] = new_e;
          end
        end
        2'b10: begin
          fifo_d[count_q[0]] = new_e;
          count_d            = count_q + 2'd1;
        end
        2'b01: begin
          fifo_d[0] = fifo_q[1];
          count_d   = count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, backpressure,
// redirect/flush, pc wrap, reset mid-run, redirect racing a pop.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, start, redirect, out_ready;
  logic [8:0]  ra, redirect_pc, out_pc;
  logic [31:0] rd, out_instr;
  logic        out_valid;

  logic [31:0] mem [0:127];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rd = mem[ra[8:2]];

  instruction_fetch #(.INS_ADDRESS(9), .INS_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ra(ra), .rd(rd),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_ready(out_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [8:0] pc, input logic [31:0] ins);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".pc"}, {23'd0, out_pc}, {23'd0, pc});
    chk({tag, ".instr"}, out_instr, ins);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE0000 + i;
    mem[0] = 32'h00007033;
    mem[1] = 32'h00100093;
    mem[2] = 32'h00200113;

    reset = 1'b1; start = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.pc", {23'd0, out_pc}, 32'd0);
    chk("rst.instr", out_instr, 32'd0);
    chk("rst.ra", {23'd0, ra}, 32'd0);

    // idle: no fetch without start
    reset = 1'b0;
    tick();
    chk("idle.valid", {31'd0, out_valid}, 32'd0);
    chk("idle.ra", {23'd0, ra}, 32'd0);

    // sequential fetch
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_entry.valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_head("seq0", 9'h000, 32'h00007033);
    chk("seq0.ra", {23'd0, ra}, 32'h4);
    tick();
    chk_head("seq1", 9'h004, 32'h00100093);
    tick();
    chk_head("seq2", 9'h008, 32'h00200113);

    // backpressure from a fresh start
    reset = 1'b1; tick();
    reset = 1'b0; start = 1'b1; out_ready = 1'b0; tick();
    start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk_head("bp.hold", 9'h000, 32'h00007033);
    chk("bp.ra", {23'd0, ra}, 32'h8);
    out_ready = 1'b1;
    tick();
    chk_head("bp.rel0", 9'h004, 32'h00100093);
    chk("bp.rel0.ra", {23'd0, ra}, 32'hC);
    tick();
    chk_head("bp.rel1", 9'h008, 32'h00200113);
    tick();
    chk_head("bp.rel2", 9'h00C, 32'hC0DE0003);
    chk("bp.rel2.ra", {23'd0, ra}, 32'h14);

    // redirect with two entries buffered
    out_ready = 1'b0;
    tick();
    chk_head("full.hold", 9'h00C, 32'hC0DE0003);
    redirect = 1'b1; redirect_pc = 9'h02B;
    tick();
    redirect = 1'b0; out_ready = 1'b1;
    chk("rd.flush.valid", {31'd0, out_valid}, 32'd0);
    chk("rd.flush.ra", {23'd0, ra}, 32'h28);
    tick();
    chk("rd.run.valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_head("rd.first", 9'h028, 32'hC0DE000A);

    // redirect again while in FLUSH
    redirect = 1'b1; redirect_pc = 9'h040;
    tick();
    redirect_pc = 9'h063;
    tick();
    redirect = 1'b0;
    chk("rr.valid", {31'd0, out_valid}, 32'd0);
    chk("rr.ra", {23'd0, ra}, 32'h60);
    tick();
    chk("rr.bubble", {31'd0, out_valid}, 32'd0);
    tick();
    chk_head("rr.first", 9'h060, 32'hC0DE0018);

    // pc wrap
    redirect = 1'b1; redirect_pc = 9'h1F8;
    tick();
    redirect = 1'b0;
    tick(); tick();
    chk_head("wrap0", 9'h1F8, 32'hC0DE007E);
    tick();
    chk_head("wrap1", 9'h1FC, 32'hC0DE007F);
    chk("wrap1.ra", {23'd0, ra}, 32'h0);
    tick();
    chk_head("wrap2", 9'h000, 32'h00007033);

    // redirect together with pop while full
    out_ready = 1'b0;
    tick();
    chk("rp.full.ra", {23'd0, ra}, 32'h8);
    redirect = 1'b1; redirect_pc = 9'h100; out_ready = 1'b1;
    tick();
    redirect = 1'b0;
    chk("rp.valid", {31'd0, out_valid}, 32'd0);
    chk("rp.ra", {23'd0, ra}, 32'h100);
    tick(); tick();
    chk_head("rp.first", 9'h100, 32'hC0DE0040);

    // reset while full in RUN
    out_ready = 1'b0;
    tick();
    chk("mr.full.ra", {23'd0, ra}, 32'h108);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr.valid", {31'd0, out_valid}, 32'd0);
    chk("mr.ra", {23'd0, ra}, 32'h0);
    chk("mr.pc", {23'd0, out_pc}, 32'h0);
    chk("mr.instr", out_instr, 32'h0);
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 9'h080;
    tick(); tick();
    redirect = 1'b0;
    chk("mr.idle.valid", {31'd0, out_valid}, 32'd0);
    chk("mr.idle.ra", {23'd0, ra}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
